// File: rtl/simple_risc_pkg.sv
// simple_risc_pkg -- shared types and constants for the SimpleRISC pipeline stages. Rev 1.0
`default_nettype none

package simple_risc_pkg;

  localparam int DATA_W = 32;
  localparam int RD_W   = 4;

  typedef enum logic [1:0] {
    MA_IDLE = 2'd0,
    MA_MEM  = 2'd1,
    MA_DONE = 2'd2
  } ma_state_t;

  // Fault cause carried with each result; anything but FLT_NONE raises maFault.
  localparam logic [1:0] FLT_NONE    = 2'd0;
  localparam logic [1:0] FLT_TIMEOUT = 2'd1;
  localparam logic [1:0] FLT_LDST    = 2'd2;
  localparam logic [1:0] FLT_ALIGN   = 2'd3;

  function automatic logic fault_any(input logic [1:0] code);
    return code != FLT_NONE;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ma_timeout_ctr.sv
// ma_timeout_ctr -- request-timeout counter; expire is high once TIMEOUT_CYC-1 idle cycles have elapsed. Rev 1.0
`default_nettype none

module ma_timeout_ctr #(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam logic [7:0] c_last = 8'(TIMEOUT_CYC - 1);

  logic [7:0] r_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= 8'd0;
    end else if (clear) begin
      r_count <= 8'd0;
    end else if (enable && !expire) begin
      r_count <= r_count + 8'd1;
    end
  end

  assign expire = (r_count == c_last);

endmodule

`default_nettype wire

// File: rtl/ma_stage.sv
// ma_stage -- SimpleRISC memory-access stage: one req/ack data-memory transaction per ld/st, registered result to writeback. Rev 1.0
// Build option MA_ALIGN_CHECK_EN: a misaligned ld/st faults without touching memory.
`default_nettype none

module ma_stage
  import simple_risc_pkg::*;
#(
  parameter int DATA_W      = simple_risc_pkg::DATA_W,
  parameter int RD_W        = simple_risc_pkg::RD_W,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              exValid,
  output logic              exReady,
  input  logic [DATA_W-1:0] aluResult,
  input  logic [DATA_W-1:0] op2,
  input  logic              isLd,
  input  logic              isSt,
  input  logic              isWb,
  input  logic [RD_W-1:0]   rd,
  output logic              memReq,
  output logic              memWe,
  output logic [DATA_W-1:0] memAddr,
  output logic [DATA_W-1:0] memWdata,
  input  logic [DATA_W-1:0] memRdata,
  input  logic              memAck,
  output logic              maValid,
  input  logic              rwReady,
  output logic [DATA_W-1:0] maResult,
  output logic [RD_W-1:0]   maRd,
  output logic              maIsWb,
  output logic              maFault
);

  ma_state_t         r_state;
  logic              r_isLd;
  logic              r_isWb;
  logic [RD_W-1:0]   r_rd;
  logic [DATA_W-1:0] r_alu;
  logic [1:0]        r_flt;

  logic w_xfer;
  logic w_both;
  logic w_memop;
  logic w_misalign;
  logic w_expire;
  logic w_ctr_clr;
  logic w_ctr_en;

`ifdef MA_ALIGN_CHECK_EN
  assign w_misalign = |aluResult[1:0];
`else
  assign w_misalign = 1'b0;
`endif

  // Held low during reset so nothing is accepted while the stage is being cleared.
  assign exReady   = !reset && ((r_state == MA_IDLE) || ((r_state == MA_DONE) && rwReady));
  assign w_xfer    = exValid && exReady;
  assign w_both    = isLd && isSt;
  assign w_memop   = isLd ^ isSt;
  assign w_ctr_clr = w_xfer && w_memop && !w_misalign;
  assign w_ctr_en  = (r_state == MA_MEM) && !memAck;
  assign maFault   = fault_any(r_flt);

  ma_timeout_ctr #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timeout (
    .clk   (clk),
    .reset (reset),
    .clear (w_ctr_clr),
    .enable(w_ctr_en),
    .expire(w_expire)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= MA_IDLE;
      r_isLd   <= 1'b0;
      r_isWb   <= 1'b0;
      r_rd     <= '0;
      r_alu    <= '0;
      r_flt    <= FLT_NONE;
      memReq   <= 1'b0;
      memWe    <= 1'b0;
      memAddr  <= '0;
      memWdata <= '0;
      maValid  <= 1'b0;
      maResult <= '0;
      maRd     <= '0;
      maIsWb   <= 1'b0;
    end else if (w_xfer) begin
      r_isLd <= isLd;
      r_isWb <= isWb;
      r_rd   <= rd;
      r_alu  <= aluResult;
      if (w_both || (w_memop && w_misalign)) begin
        r_state  <= MA_DONE;
        r_flt    <= w_both ? FLT_LDST : FLT_ALIGN;
        maValid  <= 1'b1;
        maResult <= '0;
        maRd     <= rd;
        maIsWb   <= 1'b0;
      end else if (w_memop) begin
        r_state  <= MA_MEM;
        r_flt    <= FLT_NONE;
        memReq   <= 1'b1;
        memWe    <= isSt;
        memAddr  <= aluResult;
        memWdata <= op2;
        maValid  <= 1'b0;
      end else begin
        r_state  <= MA_DONE;
        r_flt    <= FLT_NONE;
        maValid  <= 1'b1;
        maResult <= aluResult;
        maRd     <= rd;
        maIsWb   <= isWb;
      end
    end else begin
      case (r_state)
        MA_MEM: begin
          // An ack on the expiry cycle still completes the access normally.
          if (memAck) begin
            r_state  <= MA_DONE;
            memReq   <= 1'b0;
            maValid  <= 1'b1;
            maResult <= r_isLd ? memRdata : r_alu;
            maRd     <= r_rd;
            maIsWb   <= r_isWb;
          end else if (w_expire) begin
            r_state  <= MA_DONE;
            r_flt    <= FLT_TIMEOUT;
            memReq   <= 1'b0;
            maValid  <= 1'b1;
            maResult <= '0;
            maRd     <= r_rd;
            maIsWb   <= 1'b0;
          end
        end
        MA_DONE: begin
          if (rwReady) begin
            r_state <= MA_IDLE;
            r_flt   <= FLT_NONE;
            maValid <= 1'b0;
          end
        end
        default: begin
          r_state <= MA_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: doc/ma_stage.md
Name: ma_stage

Overview:
- Memory-access stage of the SimpleRISC pipeline, directly downstream of the ALU.
- Takes aluResult as the effective address for ld/st, op2 as store data, and the destination/writeback tags.
- Performs one data-memory transaction per ld/st over a req/ack interface, with a timeout.
- Hands a registered result (load data or pass-through aluResult) to the register-writeback stage over a valid/ready handshake.

Parameters:
- DATA_W, 32, width of data, address, aluResult and ldResult.
- RD_W, 4, destination register index width (16 registers).
- TIMEOUT_CYC, 16, cycles memReq may stay unacknowledged before fault; legal range 2..255.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- exValid  in  1  EX stage presents an instruction.
- exReady  out  1  ma_stage accepts this cycle (transfer = exValid & exReady).
- aluResult  in  DATA_W  ALU output; address for ld/st, else the result value.
- op2  in  DATA_W  store data.
- isLd  in  1  load.
- isSt  in  1  store.
- isWb  in  1  instruction writes a register.
- rd  in  RD_W  destination register.
- memReq  out  1  memory request, held until ack.
- memWe  out  1  1 = write.
- memAddr  out  DATA_W  request address.
- memWdata  out  DATA_W  write data.
- memRdata  in  DATA_W  read data, valid with memAck.
- memAck  in  1  completes the outstanding request.
- maValid  out  1  result available to writeback.
- rwReady  in  1  writeback accepts (transfer = maValid & rwReady).
- maResult  out  DATA_W  load data, or aluResult for non-load.
- maRd  out  RD_W  registered rd.
- maIsWb  out  1  registered isWb (forced 0 on fault).
- maFault  out  1  sticky per-result fault: timeout or ld&st both set.

Behaviour:
- Reset: every output is 0, state is IDLE, timeout counter is 0.
- FSM states: IDLE, MEM, DONE. exReady = (state==IDLE) | (state==DONE & rwReady).
- On transfer, all inputs are registered.
  - isLd^isSt: go to MEM. memReq=1 the next cycle; memWe=isSt, memAddr=aluResult, memWdata=op2.
  - Neither set: go to DONE with maResult=aluResult and maValid=1 one cycle after acceptance.
  - Both set: go to DONE with maFault=1, maIsWb=0, maResult=0, and no memory access.
- MEM:
  - memReq and its address/data/we stay stable until memAck is sampled high.
  - On memAck: go to DONE. maResult=memRdata for a load, aluResult for a store. memReq drops on the same edge.
  - The counter increments each MEM cycle without ack. When it reaches TIMEOUT_CYC-1 without ack: go to DONE with maFault=1, maResult=0, maIsWb=0, and memReq dropped.
- Latency: non-memory 1 cycle; memory 1 + N cycles, where N ≥ 1 is the cycle memAck arrives.
- DONE: maValid is held with stable outputs until rwReady.
  - rwReady & exValid: accept the next instruction in the same cycle (back-to-back, no bubble).
  - rwReady only: go to IDLE with maValid=0.
- memAck outside MEM is ignored. memAck arriving in the same cycle as the timeout wins; no fault.
- Reset mid-MEM drops memReq at that edge and abandons the result.
- The counter clears on entry to MEM.
- aluResult is passed unchanged; no arithmetic in this block.

Optional Feature:
- Macro: MA_ALIGN_CHECK_EN.
- Defined: a ld/st with aluResult[1:0]!=0 skips MEM and goes to DONE with maFault=1, maIsWb=0, maResult=0. memReq is never raised.
- Undefined: no alignment check; memAddr is passed unaligned and memory handles it.

Decomposition:
- simple_risc_pkg holds:
  - ma_state_t enum {IDLE, MEM, DONE};
  - DATA_W and RD_W constants;
  - the fault encoding.
- One sub-module, ma_timeout_ctr: clear, enable, expire output, with TIMEOUT_CYC as its parameter.

Test Plan:
- Non-memory pass-through: aluResult=8, isWb=1, rd=3, rwReady=1 -> maValid the next cycle, maResult=8, maRd=3, memReq never 1.
- Load: aluResult=0x1020, isLd=1, memAck 2 cycles after memReq with memRdata=0xDEADBEEF -> memAddr=0x1020, memWe=0, then maResult=0xDEADBEEF, maValid 3 cycles after acceptance.
- Store then back-pressure: aluResult=0x1000, op2=0x20, isSt=1, ack immediately, rwReady=0 for 3 cycles -> memWe=1, memWdata=0x20; maValid is held with stable outputs and exReady=0 until rwReady.
- Timeout: isLd, memAck never asserted, TIMEOUT_CYC=16 -> memReq drops after 16 cycles, maFault=1, maIsWb=0, maResult=0.
- Back-to-back: in DONE with rwReady=1 and exValid=1 -> the new instruction is accepted in that cycle, with no idle bubble.
- Reset asserted while in MEM -> the next cycle has memReq=0 and maValid=0; a later memAck is ignored. With MA_ALIGN_CHECK_EN defined, an ld at 0x1002 -> fault and no memReq.
